// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - state encoding, opcodes and widths shared by the accumulator CPU controller
package controller_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // Four bits leave spare encodings so a corrupted state register can be recovered.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LDA    = 4'd3,
        S_STA    = 4'd4,
        S_ADD    = 4'd5,
        S_JMP    = 4'd6,
        S_ERROR  = 4'd7
    } state_e;

endpackage

// File: rtl/controller.sv
// rtl/controller.sv - fetch/decode/execute sequencer with memory wait timeout
module controller
    import controller_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       opcode,
    input  logic             memReady,
    output logic             pass,
    output logic             add,
    output logic             ldAc,
    output logic             ldIr,
    output logic             incPc,
    output logic             ldPc,
    output logic             irOnAdr,
    output logic             pcOnAdr,
    output logic             rdMem,
    output logic             wrMem,
    output logic             selAlu,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instrCnt
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rst_done_q;
    logic               timeout;
    state_e             after_exec;

    // rst_done_q holds off the first fetch until one full edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            cnt_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            rst_done_q <= 1'b1;
        end
    end

    assign timeout    = !memReady && (wait_q == WAIT_LIM);
    assign after_exec = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass    = 1'b0;
        add     = 1'b0;
        ldAc    = 1'b0;
        ldIr    = 1'b0;
        incPc   = 1'b0;
        ldPc    = 1'b0;
        irOnAdr = 1'b0;
        pcOnAdr = 1'b0;
        rdMem   = 1'b0;
        wrMem   = 1'b0;
        selAlu  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && rst_done_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                pcOnAdr = 1'b1;
                rdMem   = 1'b1;
                if (memReady) begin
                    ldIr    = 1'b1;
                    incPc   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                cnt_d = cnt_q + 1'b1;
                case (opcode)
                    OP_LDA:  state_d = S_LDA;
                    OP_STA:  state_d = S_STA;
                    OP_ADD:  state_d = S_ADD;
                    default: state_d = S_JMP;
                endcase
            end
            S_LDA: begin
                irOnAdr = 1'b1;
                rdMem   = 1'b1;
                if (memReady) begin
                    ldAc    = 1'b1;
                    state_d = after_exec;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_STA: begin
                irOnAdr = 1'b1;
                pass    = 1'b1;
                wrMem   = 1'b1;
                if (memReady) state_d = after_exec;
                else if (timeout) state_d = S_ERROR;
            end
            S_ADD: begin
                add     = 1'b1;
                selAlu  = 1'b1;
                ldAc    = 1'b1;
                state_d = after_exec;
            end
            S_JMP: begin
                ldPc    = 1'b1;
                state_d = after_exec;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // The counter restarts on every state change, so each access gets its own budget.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (!memReady &&
                     (state_q == S_FETCH || state_q == S_LDA || state_q == S_STA)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign err      = (state_q == S_ERROR);
    assign instrCnt = cnt_q;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed-vector bench for controller with a small accumulator datapath model
module tb_controller;

    localparam logic [10:0] C_PASS  = 11'h400;
    localparam logic [10:0] C_ADD   = 11'h200;
    localparam logic [10:0] C_LDAC  = 11'h100;
    localparam logic [10:0] C_LDIR  = 11'h080;
    localparam logic [10:0] C_INCPC = 11'h040;
    localparam logic [10:0] C_LDPC  = 11'h020;
    localparam logic [10:0] C_IRADR = 11'h010;
    localparam logic [10:0] C_PCADR = 11'h008;
    localparam logic [10:0] C_RD    = 11'h004;
    localparam logic [10:0] C_WR    = 11'h002;
    localparam logic [10:0] C_SEL   = 11'h001;

    logic       clk, rst_n, run, memReady;
    logic [1:0] opcode;
    logic       pass, add, ldAc, ldIr, incPc, ldPc, irOnAdr, pcOnAdr;
    logic       rdMem, wrMem, selAlu, busy, err;
    logic [7:0] instrCnt;

    logic [7:0]  mem [0:63];
    logic [5:0]  pc;
    logic [7:0]  ir, ac;
    logic [5:0]  adr_bus;
    logic [5:0]  wr_adr;
    logic [7:0]  wr_data;
    logic [10:0] ctl;

    int n_vec = 0;
    int n_err = 0;

    controller #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .memReady(memReady),
        .pass(pass), .add(add), .ldAc(ldAc), .ldIr(ldIr), .incPc(incPc), .ldPc(ldPc),
        .irOnAdr(irOnAdr), .pcOnAdr(pcOnAdr), .rdMem(rdMem), .wrMem(wrMem),
        .selAlu(selAlu), .busy(busy), .err(err), .instrCnt(instrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ctl     = {pass, add, ldAc, ldIr, incPc, ldPc, irOnAdr, pcOnAdr, rdMem, wrMem, selAlu};
    assign adr_bus = pcOnAdr ? pc : (irOnAdr ? ir[5:0] : 6'h00);
    assign opcode  = ir[7:6];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
            ac <= '0;
        end else begin
            if (ldIr) ir <= mem[adr_bus];
            if (incPc) pc <= pc + 6'd1;
            if (ldPc) pc <= ir[5:0];
            if (ldAc) ac <= add ? ac + {2'b00, ir[5:0]} : mem[adr_bus];
            if (wrMem && memReady) begin
                wr_adr  <= adr_bus;
                wr_data <= pass ? ac : 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h05;
        mem[1] = 8'h83;
        mem[2] = 8'h4A;
        mem[3] = 8'hC0;
        mem[5] = 8'h21;
        wr_adr   = 6'h3F;
        wr_data  = 8'hEE;
        rst_n    = 1'b0;
        run      = 1'b0;
        memReady = 1'b1;
        step();
        step();
        check("rst_ctl", 32'(ctl), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", 32'(instrCnt), 32'h0);

        rst_n = 1'b1;
        run   = 1'b1;
        step();
        check("first_edge_idle", 32'(busy), 32'h0);
        step();
        check("fetch0_ctl", 32'(ctl), 32'(C_PCADR | C_RD | C_LDIR | C_INCPC));
        check("fetch0_adr", 32'(adr_bus), 32'h00);
        step();
        check("decode_ctl", 32'(ctl), 32'h0);
        check("decode_busy", 32'(busy), 32'h1);
        step();
        check("lda_ctl", 32'(ctl), 32'(C_IRADR | C_RD | C_LDAC));
        check("lda_adr", 32'(adr_bus), 32'h05);
        step();
        check("lda_ac", 32'(ac), 32'h21);
        check("lda_cnt", 32'(instrCnt), 32'h1);
        check("fetch1_adr", 32'(adr_bus), 32'h01);
        step();
        step();
        check("add_ctl", 32'(ctl), 32'(C_ADD | C_SEL | C_LDAC));
        step();
        check("add_ac", 32'(ac), 32'h24);
        check("add_once", 32'(ctl), 32'(C_PCADR | C_RD | C_LDIR | C_INCPC));
        step();
        step();
        check("sta_ctl", 32'(ctl), 32'(C_IRADR | C_PASS | C_WR));
        check("sta_adr", 32'(adr_bus), 32'h0A);
        step();
        check("sta_wadr", 32'(wr_adr), 32'h0A);
        check("sta_wdata", 32'(wr_data), 32'h24);
        check("fetch3_adr", 32'(adr_bus), 32'h03);
        step();
        step();
        check("jmp_ctl", 32'(ctl), 32'(C_LDPC));
        step();
        check("jmp_target", 32'(adr_bus), 32'h00);
        check("jmp_cnt", 32'(instrCnt), 32'h4);

        // FETCH stretched by three not-ready cycles
        memReady = 1'b0;
        #1;
        check("fwait1_ctl", 32'(ctl), 32'(C_PCADR | C_RD));
        step();
        check("fwait2_ctl", 32'(ctl), 32'(C_PCADR | C_RD));
        step();
        check("fwait3_ctl", 32'(ctl), 32'(C_PCADR | C_RD));
        step();
        memReady = 1'b1;
        #1;
        check("fwait4_ctl", 32'(ctl), 32'(C_PCADR | C_RD | C_LDIR | C_INCPC));
        step();
        check("fwait_decode", 32'(ctl), 32'h0);
        step();
        memReady = 1'b0;
        #1;
        check("ldawait_ctl", 32'(ctl), 32'(C_IRADR | C_RD));
        for (int i = 0; i < 15; i++) step();
        check("ldawait_last_busy", 32'(busy), 32'h1);
        check("ldawait_last_err", 32'(err), 32'h0);
        step();
        check("timeout_err", 32'(err), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_ctl", 32'(ctl), 32'h0);
        check("timeout_cnt", 32'(instrCnt), 32'h5);
        memReady = 1'b1;
        step();
        check("error_held", 32'(err), 32'h1);
        check("error_ctl", 32'(ctl), 32'h0);

        #2 rst_n = 1'b0;
        #1;
        check("errrst_err", 32'(err), 32'h0);
        check("errrst_busy", 32'(busy), 32'h0);
        check("errrst_cnt", 32'(instrCnt), 32'h0);

        // Second run: STA held to the last allowed wait cycle while run drops
        mem[0] = 8'h4B;
        step();
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        step();
        check("run2_fetch", 32'(ctl), 32'(C_PCADR | C_RD | C_LDIR | C_INCPC));
        step();
        step();
        memReady = 1'b0;
        run      = 1'b0;
        #1;
        check("sta2_ctl", 32'(ctl), 32'(C_IRADR | C_PASS | C_WR));
        for (int i = 0; i < 15; i++) step();
        check("sta2_still", 32'(ctl), 32'(C_IRADR | C_PASS | C_WR));
        memReady = 1'b1;
        step();
        check("sta2_idle", 32'(busy), 32'h0);
        check("sta2_noerr", 32'(err), 32'h0);
        check("sta2_wadr", 32'(wr_adr), 32'h0B);
        check("sta2_wdata", 32'(wr_data), 32'h00);
        check("sta2_cnt", 32'(instrCnt), 32'h1);

        run      = 1'b1;
        memReady = 1'b0;
        step();
        check("run3_fetch", 32'(ctl), 32'(C_PCADR | C_RD));
        #2 rst_n = 1'b0;
        #1;
        check("midfetch_ctl", 32'(ctl), 32'h0);
        check("midfetch_busy", 32'(busy), 32'h0);
        check("midfetch_cnt", 32'(instrCnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
